muldiv_unit: RTL and testbench

Iterative signed multiply/divide unit with architectural HI/LO registers, sitting in the execute stage directly downstream of the main decoder. It consumes the decoder's `hlwrite` (start) and `multordiv` (1 = MULT, 0 = DIV) controls with the two register operands. It produces a 64-bit result into HI/LO over a fixed multi-cycle latency, and raises `busy` so the hazard unit stalls the pipeline.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/muldiv_unit.sv | 116 +++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared execute-stage definitions: multiply/divide FSM states, decoder opcodes
// and the two's-complement helpers used by the HI/LO unit and its neighbours.
package mips_pkg;

    localparam int XLEN     = 32;
    localparam int MD_ITERS = 32;

    localparam logic [5:0] OP_MULT = 6'b011000;
    localparam logic [5:0] OP_DIV  = 6'b011010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // Wraps modulo 2^XLEN, so negating -2^31 yields 0x8000_0000 again.
    function automatic logic [XLEN-1:0] md_neg(input logic [XLEN-1:0] x);
        return {XLEN{1'b0}} - x;
    endfunction

    function automatic logic [2*XLEN-1:0] md_neg64(input logic [2*XLEN-1:0] x);
        return {(2*XLEN){1'b0}} - x;
    endfunction

    function automatic logic [XLEN-1:0] md_abs(input logic signed [XLEN-1:0] x);
        return (x < 0) ? md_neg(x) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed MULT/DIV with architectural HI/LO. Operands are reduced to
// magnitudes on start, iterated unsigned for 32 cycles, and sign-fixed on write.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hlwrite,
    input  logic             multordiv,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t state, state_next;
    logic [4:0]         cnt;

    logic               op_mult;
    logic               sign_res;
    logic               sign_rem;
    logic               dbz;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_sub;

    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;

    assign sa = signed'(srca);
    assign sb = signed'(srcb);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hlwrite) state_next = CALC;
            CALC:    if (cnt == 5'd0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Restoring division step: shift in next dividend bit, subtract if it fits.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, divisor};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == FIX);
            if (state == IDLE && hlwrite) begin
                cnt <= 5'(MD_ITERS - 1);
            end else if (state == CALC) begin
                cnt <= cnt - 5'd1;
            end
            if (state == FIX) begin
                if (op_mult) begin
                    {hi, lo} <= sign_res ? md_neg64(acc) : acc;
                end else if (dbz) begin
                    lo <= '1;
                    hi <= a_raw;
                end else begin
                    lo <= sign_res ? md_neg(quo) : quo;
                    hi <= sign_rem ? md_neg(rem) : rem;
                end
            end
        end
    end

    // Datapath registers carry no reset: the FSM alone decides when they matter.
    always_ff @(posedge clk) begin
        if (state == IDLE && hlwrite) begin
            op_mult  <= multordiv;
            sign_res <= (sa < 0) ^ (sb < 0);
            sign_rem <= (sa < 0);
            dbz      <= (srcb == '0);
            a_raw    <= srca;
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, md_abs(sa)};
            mplier   <= md_abs(sb);
            divisor  <= md_abs(sb);
            rem      <= '0;
            quo      <= md_abs(sa);
        end else if (state == CALC) begin
            acc    <= acc + (mplier[0] ? mcand : {(2*WIDTH){1'b0}});
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (!rem_sub[WIDTH]) begin
                rem <= rem_sub[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= rem_sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency profile, signed MULT/DIV corner cases,
// ignored restarts, back-to-back issue and reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hlwrite = 1'b0;
    logic        multordiv = 1'b0;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .hlwrite   (hlwrite),
        .multordiv (multordiv),
        .srca      (srca),
        .srcb      (srcb),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Drives hlwrite during cycle 0 and returns at the middle of cycle 1.
    task automatic start_op(input logic m, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        hlwrite   = 1'b1;
        multordiv = m;
        srca      = a;
        srcb      = b;
        @(negedge clk);
        hlwrite = 1'b0;
        srca    = $urandom;
        srcb    = $urandom;
    endtask

    // From the middle of cycle 1, walks to the middle of cycle 34 and reports
    // whether busy/done followed the expected profile with HI/LO held meanwhile.
    task automatic track(output logic ok);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        ok = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            if (!(busy === 1'b1 && done === 1'b0 && hi === h0 && lo === l0)) ok = 1'b0;
            @(negedge clk);
        end
        if (!(busy === 1'b0 && done === 1'b1)) ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h required all zero",
                     busy, done, hi, lo);
        end
        reset = 1'b1;
    endtask

    task automatic test_mult();
        logic [31:0] ta [2] = '{32'd7, 32'h8000_0000};
        logic [31:0] tb [2] = '{32'hFFFF_FFFD, 32'h8000_0000};
        logic [31:0] eh [2] = '{32'hFFFF_FFFF, 32'h4000_0000};
        logic [31:0] el [2] = '{32'hFFFF_FFEB, 32'h0000_0000};
        logic ok;
        for (int i = 0; i < 2; i++) begin
            start_op(1'b1, ta[i], tb[i]);
            track(ok);
            checks++;
            if (ok !== 1'b1) begin
                failures++;
                $display("FAIL mult%0d_timing: got busy/done profile bad, required busy 1-33 done 34", i);
            end
            checks++;
            if (hi !== eh[i] || lo !== el[i]) begin
                failures++;
                $display("FAIL mult%0d_result: got hi=%h lo=%h required hi=%h lo=%h",
                         i, hi, lo, eh[i], el[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL mult%0d_done_pulse: got done=%b in cycle 35 required 0", i, done);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] ta [5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'd7};
        logic [31:0] tb [5] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE};
        logic [31:0] eh [5] = '{32'hFFFF_FFFF, 32'h0, 32'd5, 32'hFFFF_FFFB, 32'd1};
        logic [31:0] el [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        logic ok;
        for (int i = 0; i < 5; i++) begin
            start_op(1'b0, ta[i], tb[i]);
            track(ok);
            checks++;
            if (ok !== 1'b1) begin
                failures++;
                $display("FAIL div%0d_timing: got busy/done profile bad, required busy 1-33 done 34", i);
            end
            checks++;
            if (hi !== eh[i] || lo !== el[i]) begin
                failures++;
                $display("FAIL div%0d_result: got hi=%h lo=%h required hi=%h lo=%h",
                         i, hi, lo, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        start_op(1'b0, 32'd100, 32'd7);
        ok = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            if (c == 10) begin
                hlwrite   = 1'b1;
                multordiv = 1'b1;
                srca      = 32'd9;
                srcb      = 32'd9;
            end else begin
                hlwrite = 1'b0;
            end
            if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (ok !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL ignore_start_timing: got busy=%b done=%b profile_ok=%b required busy=0 done=1 ok=1",
                     busy, done, ok);
        end
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            failures++;
            $display("FAIL ignore_start_result: got hi=%h lo=%h required hi=00000002 lo=0000000e", hi, lo);
        end
        // New start issued in cycle 34, no dead cycle.
        hlwrite   = 1'b1;
        multordiv = 1'b1;
        srca      = 32'd6;
        srcb      = 32'd7;
        @(negedge clk);
        hlwrite = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%b done=%b in cycle 35 required busy=1 done=0", busy, done);
        end
        track(ok);
        checks++;
        if (ok !== 1'b1 || hi !== 32'd0 || lo !== 32'd42) begin
            failures++;
            $display("FAIL b2b_result: got ok=%b hi=%h lo=%h required ok=1 hi=00000000 lo=0000002a",
                     ok, hi, lo);
        end
    endtask

    task automatic test_reset_abort();
        logic ok;
        logic saw_done;
        start_op(1'b1, 32'd3, 32'd4);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL abort_state: got busy=%b done=%b hi=%h lo=%h required all zero",
                     busy, done, hi, lo);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet: got activity after reset abort required none");
        end
        start_op(1'b1, 32'd3, 32'd4);
        track(ok);
        checks++;
        if (ok !== 1'b1 || hi !== 32'd0 || lo !== 32'd12) begin
            failures++;
            $display("FAIL abort_restart: got ok=%b hi=%h lo=%h required ok=1 hi=00000000 lo=0000000c",
                     ok, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
